// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//   data width, register word offsets, store-mode codes, STATUS bit
//   positions, the transmit FSM state type and the divider helper.
//   Ports: none (package).

package uart_mmio_pkg;

  localparam int XLEN = 32;

  // Register word offsets inside the 16-byte window (address bits [3:2]).
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;

  // Store-port mode codes, shared with the data RAM.
  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_WORD = 2'b11;

  // STATUS bit positions; the 4-bit FIFO count sits at STAT_COUNT_LSB.
  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } txState_e;

  // A programmed divider of zero behaves as one cycle per bit.
  function automatic logic [15:0] effectiveDiv(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// uart_mmio_sync_fifo
//   Single-clock FIFO holding bytes waiting to be serialised.
//   The caller decides whether a push is allowed (it may push into a
//   full FIFO only in a cycle that also pops).
//   Ports:
//     clk, rst     clock and synchronous active-high reset
//     push_i       write pushData_i at the tail this cycle
//     pushData_i   data to enqueue
//     pop_i        drop the head entry this cycle
//     popData_o    current head entry (valid while not empty)
//     full_o       count == DEPTH
//     empty_o      count == 0
//     count_o      number of stored entries, 0..DEPTH

module uart_mmio_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         pushData_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         popData_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;

  // Storage array carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  // A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        wrPtr_q <= wrPtr_q + PW'(1);
      end
      if (pop_i) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign popData_o = mem_q[rdPtr_q];
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio
//   Memory-mapped 8N1 UART transmitter on the core's store port and
//   second read port. Bytes stored to TXDATA are queued and shifted out
//   LSB first on tx; software polls STATUS and programs the bit period
//   through DIV.
//   Ports:
//     clk, rst     clock and synchronous active-high reset
//     write_mode   00 none, 01 byte, 10 half, 11 word
//     write_addr   store address
//     write_data   store data, LSB-aligned
//     read_addr    load address
//     read_data    combinational register read, 0 when unmapped
//     tx           serial output, idle high
//     irq_empty    registered, high while FIFO empty and shifter idle

module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] CLK_DIV    = 16'd16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      write_mode,
  input  logic [XLEN-1:0] write_addr,
  input  logic [XLEN-1:0] write_data,
  input  logic [XLEN-1:0] read_addr,
  output logic [XLEN-1:0] read_data,
  output logic            tx,
  output logic            irq_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic           wrHit;
  logic           rdHit;
  logic [1:0]     wrOff;
  logic [1:0]     rdOff;
  logic           pushReq;
  logic           pushAcc;
  logic           popNow;
  logic           statusWr;
  logic           divWr;

  logic           fifoFull;
  logic           fifoEmpty;
  logic [CW-1:0]  fifoCount;
  logic [7:0]     fifoHead;

  txState_e       state_q;
  logic [15:0]    baudCnt_q;
  logic [15:0]    bitDiv_q;
  logic [2:0]     bitIdx_q;
  logic [7:0]     shift_q;
  logic           tx_q;
  logic           irq_q;
  logic           baudEnd;

  logic [15:0]    div_q;
  logic [15:0]    div_d;
  logic           ovf_q;
  logic           ovf_d;

  logic [XLEN-1:0] status;
  logic            unusedBits;

  // Window decode ignores the byte-lane bits; offsets are word-granular.
  assign wrHit    = (write_mode != MODE_NONE) &&
                    (write_addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign rdHit    = (read_addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign wrOff    = write_addr[3:2];
  assign rdOff    = read_addr[3:2];

  assign pushReq  = wrHit && (wrOff == OFF_TXDATA);
  assign statusWr = wrHit && (wrOff == OFF_STATUS);
  assign divWr    = wrHit && (wrOff == OFF_DIV) && (write_mode == MODE_WORD);

  // The last cycle of the current bit/step.
  assign baudEnd  = (baudCnt_q == (bitDiv_q - 16'd1));

  // The shifter takes a new byte either from idle or at the end of a
  // stop bit, which keeps back-to-back frames gap-free.
  assign popNow   = !fifoEmpty &&
                    ((state_q == TX_IDLE) || ((state_q == TX_STOP) && baudEnd));

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign pushAcc  = pushReq && (!fifoFull || popNow);

  uart_mmio_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (pushAcc),
    .pushData_i (write_data[7:0]),
    .pop_i      (popNow),
    .popData_o  (fifoHead),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount)
  );

  // Next values of the software-visible DIV and sticky overflow flag.
  // Only full-word stores may change DIV.
  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (divWr) begin
      div_d = write_data[15:0];
    end
    if (pushReq && !pushAcc) begin
      ovf_d = 1'b1;
    end
    if (statusWr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= CLK_DIV;
      ovf_q <= 1'b0;
    end else begin
      div_q <= div_d;
      ovf_q <= ovf_d;
    end
  end

  // Transmit FSM with registered tx and irq. bitDiv_q captures the
  // divider at every bit boundary, so a DIV write mid-bit never shortens
  // the bit in progress. irq_q is set to the post-edge "FIFO empty and
  // idle" condition so it never lags the state it reports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      baudCnt_q <= '0;
      bitDiv_q  <= 16'd1;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (popNow) begin
            state_q   <= TX_START;
            shift_q   <= fifoHead;
            tx_q      <= 1'b0;
            baudCnt_q <= '0;
            bitDiv_q  <= effectiveDiv(div_q);
            irq_q     <= 1'b0;
          end else begin
            tx_q      <= 1'b1;
            irq_q     <= !pushAcc;
          end
        end
        TX_START: begin
          if (baudEnd) begin
            state_q   <= TX_DATA;
            bitIdx_q  <= '0;
            tx_q      <= shift_q[0];
            baudCnt_q <= '0;
            bitDiv_q  <= effectiveDiv(div_q);
          end else begin
            baudCnt_q <= baudCnt_q + 16'd1;
          end
        end
        TX_DATA: begin
          if (baudEnd) begin
            baudCnt_q <= '0;
            bitDiv_q  <= effectiveDiv(div_q);
            if (bitIdx_q == 3'd7) begin
              state_q <= TX_STOP;
              tx_q    <= 1'b1;
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
              tx_q     <= shift_q[1];
              shift_q  <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baudCnt_q <= baudCnt_q + 16'd1;
          end
        end
        TX_STOP: begin
          if (baudEnd) begin
            baudCnt_q <= '0;
            bitDiv_q  <= effectiveDiv(div_q);
            if (popNow) begin
              state_q <= TX_START;
              shift_q <= fifoHead;
              tx_q    <= 1'b0;
            end else begin
              state_q <= TX_IDLE;
              tx_q    <= 1'b1;
              irq_q   <= !pushAcc;
            end
          end else begin
            baudCnt_q <= baudCnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= TX_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  // Register read mux; values are pre-edge so a same-cycle write is
  // not visible until the following cycle.
  always_comb begin
    status = '0;
    status[STAT_BUSY]                = (state_q != TX_IDLE);
    status[STAT_FULL]                = fifoFull;
    status[STAT_EMPTY]               = fifoEmpty;
    status[STAT_OVF]                 = ovf_q;
    status[STAT_COUNT_LSB +: 4]      = 4'(fifoCount);

    read_data = '0;
    if (rdHit) begin
      case (rdOff)
        OFF_STATUS: read_data = status;
        OFF_DIV:    read_data = XLEN'(div_q);
        default:    read_data = '0;
      endcase
    end
  end

  assign tx         = tx_q;
  assign irq_empty  = irq_q;

  // Byte-lane address bits and upper store data have no function here.
  assign unusedBits = ^{write_addr[1:0], read_addr[1:0], write_data[XLEN-1:16]};

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio
//   Self-checking bench for uart_mmio: register decode tables, DIV write
//   rules, frame timing, overflow, reset abort and randomized bursts.
//   Expected serial waveforms are built from the 8N1 framing rules.

module tb_uart_mmio;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  write_mode;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic [31:0] read_addr;
  logic [31:0] read_data;
  logic        tx;
  logic        irq_empty;

  int compared   = 0;
  int mismatched = 0;

  bit capture = 1'b0;
  bit txTrace[$];
  bit busyTrace[$];
  bit irqTrace[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } readVec_t;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] expDiv;
  } divVec_t;

  uart_mmio #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8),
    .CLK_DIV    (16'd16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .write_mode (write_mode),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .tx         (tx),
    .irq_empty  (irq_empty)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Advance one clock edge and sample just after it; while capturing,
  // record tx, STATUS.busy (read_addr parked on STATUS) and irq_empty.
  task automatic tick();
    @(posedge clk);
    #1;
    if (capture) begin
      txTrace.push_back(tx);
      busyTrace.push_back(read_data[0]);
      irqTrace.push_back(irq_empty);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One store lasting exactly one clock edge.
  task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] addr,
                               input logic [31:0] data);
    write_mode = mode;
    write_addr = addr;
    write_data = data;
    tick();
    write_mode = 2'b00;
    write_addr = '0;
    write_data = '0;
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
    read_addr = addr;
    #1;
    data = read_data;
  endtask

  task automatic startCapture();
    read_addr = BASE + 32'h4;
    txTrace.delete();
    busyTrace.delete();
    irqTrace.delete();
    capture = 1'b1;
  endtask

  task automatic compareTrace(input string name, input bit act[$], input bit exp[$],
                              input int len);
    int bad;
    bad = -1;
    for (int i = 0; i < len; i++) begin
      if (bad < 0 && (i >= act.size() || act[i] != exp[i])) begin
        bad = i;
      end
    end
    compared++;
    if (bad >= 0) begin
      mismatched++;
      $display("[TB] FAIL %s: first wrong sample %0d got %0b, expected %0b", name, bad,
               (bad < act.size()) ? act[bad] : 1'bx, exp[bad]);
    end
  endtask

  // Reference: the first sample follows the store edge (line still idle,
  // irq already low), then n contiguous frames of 10 bit periods each
  // (start 0, data LSB first, stop 1), then idle.
  task automatic finishAndCheck(input string tag, input int period,
                                input logic [7:0] bytes[$]);
    int len;
    int guard;
    bit lvl;
    bit expTx[$];
    bit expBusy[$];
    bit expIrq[$];
    len   = 1 + bytes.size() * 10 * period + 4;
    guard = 0;
    while (txTrace.size() < len && guard < len + 100) begin
      tick();
      guard++;
    end
    capture = 1'b0;
    checkOutput({tag, " trace length reached"}, 32'(txTrace.size() >= len), 32'd1);

    expTx.push_back(1'b1);
    expBusy.push_back(1'b0);
    expIrq.push_back(1'b0);
    foreach (bytes[k]) begin
      for (int pos = 0; pos < 10; pos++) begin
        if (pos == 0)      lvl = 1'b0;
        else if (pos == 9) lvl = 1'b1;
        else               lvl = bytes[k][pos-1];
        repeat (period) begin
          expTx.push_back(lvl);
          expBusy.push_back(1'b1);
          expIrq.push_back(1'b0);
        end
      end
    end
    repeat (4) begin
      expTx.push_back(1'b1);
      expBusy.push_back(1'b0);
      expIrq.push_back(1'b1);
    end

    compareTrace({tag, " tx"}, txTrace, expTx, len);
    compareTrace({tag, " busy"}, busyTrace, expBusy, len);
    compareTrace({tag, " irq_empty"}, irqTrace, expIrq, len);
  endtask

  initial begin
    readVec_t    rv[8];
    divVec_t     dv[8];
    logic [31:0] rd;
    logic [31:0] data;
    logic [7:0]  q[$];
    int          d;
    int          n;

    rst        = 1'b1;
    write_mode = 2'b00;
    write_addr = '0;
    write_data = '0;
    read_addr  = '0;
    repeat (3) tick();
    checkOutput("reset tx", 32'(tx), 32'd1);
    checkOutput("reset irq_empty", 32'(irq_empty), 32'd1);
    rst = 1'b0;
    tick();

    // Register decode table (idle, DIV at its reset value).
    rv[0] = '{BASE + 32'h0,  32'h0};
    rv[1] = '{BASE + 32'h4,  32'h4};
    rv[2] = '{BASE + 32'h8,  32'h10};
    rv[3] = '{BASE + 32'hC,  32'h0};
    rv[4] = '{32'h2000_0004, 32'h0};
    rv[5] = '{BASE + 32'h7,  32'h4};
    rv[6] = '{BASE + 32'h14, 32'h0};
    rv[7] = '{32'h0000_0008, 32'h0};
    for (int i = 0; i < 8; i++) begin
      readReg(rv[i].addr, rd);
      checkOutput($sformatf("read vec %0d", i), rd, rv[i].exp);
    end

    // DIV write rules, applied in order.
    dv[0] = '{2'b11, BASE + 32'h8, 32'h0000_0003, 32'h3};
    dv[1] = '{2'b01, BASE + 32'h8, 32'h0000_0009, 32'h3};
    dv[2] = '{2'b10, BASE + 32'h8, 32'h0000_0009, 32'h3};
    dv[3] = '{2'b11, BASE + 32'hB, 32'h0001_2345, 32'h2345};
    dv[4] = '{2'b11, 32'h2000_0008, 32'h0000_0007, 32'h2345};
    dv[5] = '{2'b11, BASE + 32'h8, 32'h0000_0000, 32'h0};
    dv[6] = '{2'b11, BASE + 32'h8, 32'hFFFF_0004, 32'h4};
    dv[7] = '{2'b11, BASE + 32'hC, 32'h0000_0009, 32'h4};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(dv[i].mode, dv[i].addr, dv[i].data);
      readReg(BASE + 32'h8, rd);
      checkOutput($sformatf("div vec %0d", i), rd, dv[i].expDiv);
    end

    // Single 0x55 frame at DIV=4.
    applyStimulus(2'b11, BASE + 32'h8, 32'd4);
    startCapture();
    q.delete();
    q.push_back(8'h55);
    applyStimulus(2'b11, BASE, 32'h0000_0055);
    finishAndCheck("single 0x55", 4, q);

    // Nine back-to-back byte stores while idle: all accepted.
    applyStimulus(2'b11, BASE + 32'h8, 32'd2);
    startCapture();
    q.delete();
    for (int i = 0; i < 9; i++) begin
      data = $urandom;
      q.push_back(data[7:0]);
      applyStimulus(2'b01, BASE, data);
    end
    readReg(BASE + 32'h4, rd);
    checkOutput("nine stores status", rd, 32'h83);
    finishAndCheck("nine stores", 2, q);
    readReg(BASE + 32'h4, rd);
    checkOutput("nine stores idle status", rd, 32'h4);

    // Overflow while full mid-frame, then clear by writing STATUS.
    applyStimulus(2'b11, BASE + 32'h8, 32'd8);
    startCapture();
    q.delete();
    for (int i = 0; i < 9; i++) begin
      data = $urandom;
      q.push_back(data[7:0]);
      applyStimulus(2'b10, BASE, data);
    end
    applyStimulus(2'b11, BASE, 32'h0000_00AA);
    readReg(BASE + 32'h4, rd);
    checkOutput("overflow status", rd, 32'h8B);
    applyStimulus(2'b01, BASE + 32'h4, 32'h0);
    readReg(BASE + 32'h4, rd);
    checkOutput("ovf cleared status", rd, 32'h83);
    finishAndCheck("overflow drain", 8, q);

    // DIV=0 behaves as one cycle per bit; byte store to DIV is ignored.
    applyStimulus(2'b11, BASE + 32'h8, 32'd0);
    startCapture();
    q.delete();
    q.push_back(8'hC3);
    q.push_back(8'h1E);
    applyStimulus(2'b11, BASE, 32'h0000_00C3);
    applyStimulus(2'b11, BASE, 32'h0000_001E);
    finishAndCheck("div zero", 1, q);
    applyStimulus(2'b01, BASE + 32'h8, 32'd5);
    readReg(BASE + 32'h8, rd);
    checkOutput("byte store to DIV", rd, 32'h0);

    // Reset during data bit 3 aborts the frame.
    applyStimulus(2'b11, BASE + 32'h8, 32'd4);
    applyStimulus(2'b11, BASE, 32'h0000_0000);
    applyStimulus(2'b11, BASE, 32'h0000_0081);
    applyStimulus(2'b11, BASE, 32'h0000_0042);
    repeat (15) tick();
    checkOutput("pre-reset data bit 3", 32'(tx), 32'd0);
    readReg(BASE + 32'h4, rd);
    checkOutput("pre-reset status", rd, 32'h21);
    rst = 1'b1;
    tick();
    checkOutput("post-reset tx", 32'(tx), 32'd1);
    checkOutput("post-reset irq_empty", 32'(irq_empty), 32'd1);
    readReg(BASE + 32'h4, rd);
    checkOutput("post-reset status", rd, 32'h4);
    readReg(BASE + 32'h8, rd);
    checkOutput("post-reset DIV", rd, 32'h10);
    rst = 1'b0;
    tick();
    checkOutput("after reset tx idle", 32'(tx), 32'd1);

    // Randomized bursts checked against the framing model.
    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(0, 5);
      n = $urandom_range(1, 9);
      applyStimulus(2'b11, BASE + 32'h8, 32'(d));
      startCapture();
      q.delete();
      for (int i = 0; i < n; i++) begin
        data = $urandom;
        q.push_back(data[7:0]);
        applyStimulus(2'($urandom_range(1, 3)), BASE + 32'(($urandom_range(0, 3))), data);
      end
      finishAndCheck($sformatf("random burst %0d", it), (d == 0) ? 1 : d, q);
      readReg(BASE + 32'h4, rd);
      checkOutput($sformatf("random burst %0d status", it), rd, 32'h4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
